// File: rtl/am_seq_search.sv
// am_seq_search: associative-memory search for sparse HDC inference.
// A latched query is scored against every class hypervector, one segment per
// cycle (AND + popcount), then a sequential argmax picks the winner.
// Optional feature macro: AM_MARGIN_EN adds runner-up tracking so that
// res_margin reports best minus runner-up similarity; otherwise res_margin is 0.

module am_seq_search #(
  parameter int HV_DIM      = 5000,
  parameter int NUM_CLASSES = 26,
  parameter int SEG_W       = 500,
  parameter int TALLY_W     = 11,
  localparam int CLS_W      = $clog2(NUM_CLASSES),
  localparam int SIM_W      = $clog2(HV_DIM + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [HV_DIM-1:0]             query_hv,
  input  logic [CLS_W-1:0]              correct_class,
  input  logic [NUM_CLASSES*HV_DIM-1:0] class_hvs,
  input  logic                          tally_clr,
  output logic                          res_valid,
  output logic [CLS_W-1:0]              res_class,
  output logic [SIM_W-1:0]              res_sim,
  output logic [SIM_W-1:0]              res_margin,
  output logic                          res_correct,
  output logic [TALLY_W-1:0]            tally
);

  localparam int NUM_SEGS = HV_DIM / SEG_W;
  localparam int SEG_CW   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t state, state_next;

  logic [HV_DIM-1:0] query_q;
  logic [CLS_W-1:0]  label_q;
  logic [SIM_W-1:0]  acc [NUM_CLASSES];
  logic [SIM_W-1:0]  seg_pop [NUM_CLASSES];
  logic [SEG_CW-1:0] seg_ctr;
  logic [CLS_W-1:0]  cls_ctr;
  logic [31:0]       seg_base;

  logic [SIM_W-1:0]  best, best_nx, cand;
  logic [CLS_W-1:0]  best_idx, best_idx_nx;
`ifdef AM_MARGIN_EN
  logic [SIM_W-1:0]  runner, runner_nx;
`endif

  logic seg_last, cls_last;

  assign seg_last  = (seg_ctr == SEG_CW'(NUM_SEGS - 1));
  assign cls_last  = (cls_ctr == CLS_W'(NUM_CLASSES - 1));
  assign q_ready   = (state == IDLE);
  assign res_valid = (state == DONE) && en;

  function automatic logic [SIM_W-1:0] popcount(input logic [SEG_W-1:0] v);
    logic [SIM_W-1:0] s;
    s = '0;
    for (int i = 0; i < SEG_W; i++) s = s + SIM_W'(v[i]);
    return s;
  endfunction

  // Per-class popcount of the current segment of (query AND class).
  always_comb begin
    seg_base = 32'(seg_ctr) * 32'(SEG_W);
    for (int c = 0; c < NUM_CLASSES; c++) begin
      seg_pop[c] = popcount(query_q[seg_base +: SEG_W] &
                            class_hvs[c*HV_DIM + seg_base +: SEG_W]);
    end
  end

  // One argmax step: class cls_ctr against the running best (ties keep the lower index).
  always_comb begin
    cand = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (cls_ctr == CLS_W'(c)) cand = acc[c];
    end
    best_nx     = best;
    best_idx_nx = best_idx;
`ifdef AM_MARGIN_EN
    runner_nx   = runner;
`endif
    if (cls_ctr == '0) begin
      best_nx     = cand;
      best_idx_nx = '0;
`ifdef AM_MARGIN_EN
      runner_nx   = '0;
`endif
    end else if (cand > best) begin
`ifdef AM_MARGIN_EN
      runner_nx   = best;
`endif
      best_nx     = cand;
      best_idx_nx = cls_ctr;
    end
`ifdef AM_MARGIN_EN
    else if (cand == best || cand > runner) begin
      runner_nx = cand;
    end
`endif
  end

  // Next-state logic for the IDLE -> ACCUM -> COMPARE -> DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (q_valid) state_next = ACCUM;
      ACCUM:   if (seg_last) state_next = COMPARE;
      COMPARE: if (cls_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; en low freezes the sequence, reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (en) state <= state_next;
  end

  // Query latch, accumulators, counters and the running best.
  always_ff @(posedge clk) begin
    if (rst) begin
      query_q  <= '0;
      label_q  <= '0;
      seg_ctr  <= '0;
      cls_ctr  <= '0;
      best     <= '0;
      best_idx <= '0;
`ifdef AM_MARGIN_EN
      runner   <= '0;
`endif
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (q_valid) begin
            query_q <= query_hv;
            label_q <= correct_class;
            seg_ctr <= '0;
            cls_ctr <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
          end
        end
        ACCUM: begin
          for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + seg_pop[c];
          seg_ctr <= seg_ctr + 1'b1;
          if (seg_last) cls_ctr <= '0;
        end
        COMPARE: begin
          best     <= best_nx;
          best_idx <= best_idx_nx;
`ifdef AM_MARGIN_EN
          runner   <= runner_nx;
`endif
          cls_ctr  <= cls_ctr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final compare step so they are visible during DONE.
  // A label outside the class range can never equal a class index, so it never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_class   <= '0;
      res_sim     <= '0;
      res_correct <= 1'b0;
`ifdef AM_MARGIN_EN
      res_margin  <= '0;
`endif
    end else if (en && state == COMPARE && cls_last) begin
      res_class   <= best_idx_nx;
      res_sim     <= best_nx;
      res_correct <= (label_q == best_idx_nx);
`ifdef AM_MARGIN_EN
      res_margin  <= best_nx - runner_nx;
`endif
    end
  end

`ifndef AM_MARGIN_EN
  assign res_margin = '0;
`endif

  // Correct-inference tally: clear wins, otherwise saturating increment when leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tally <= '0;
    end else if (en) begin
      if (tally_clr) tally <= '0;
      else if (state == DONE && res_correct && tally != '1) tally <= tally + 1'b1;
    end
  end

endmodule

// File: tb/tb_am_seq_search.sv
// tb_am_seq_search: directed bench for am_seq_search with a score/argmax model
// and a per-cycle compare process; a second instance with a 2-bit tally
// exercises saturation and clear.

module tb_am_seq_search;

  localparam int HV_DIM        = 5000;
  localparam int NUM_CLASSES   = 26;
  localparam int SEG_W         = 500;
  localparam int TALLY_W       = 11;
  localparam int SMALL_TALLY_W = 2;
  localparam int CLS_W         = 5;
  localparam int SIM_W         = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, en, q_valid, q_valid2, tally_clr, tally_clr2;
  logic [HV_DIM-1:0]             query_hv;
  logic [CLS_W-1:0]              correct_class;
  logic [NUM_CLASSES*HV_DIM-1:0] class_hvs;

  logic                     q_ready, res_valid, res_correct;
  logic [CLS_W-1:0]         res_class;
  logic [SIM_W-1:0]         res_sim, res_margin;
  logic [TALLY_W-1:0]       tally;

  logic                     q_ready2, res_valid2, res_correct2;
  logic [CLS_W-1:0]         res_class2;
  logic [SIM_W-1:0]         res_sim2, res_margin2;
  logic [SMALL_TALLY_W-1:0] tally2;

  am_seq_search #(.HV_DIM(HV_DIM), .NUM_CLASSES(NUM_CLASSES), .SEG_W(SEG_W), .TALLY_W(TALLY_W)) dut (
    .clk(clk), .rst(rst), .en(en), .q_valid(q_valid), .q_ready(q_ready),
    .query_hv(query_hv), .correct_class(correct_class), .class_hvs(class_hvs),
    .tally_clr(tally_clr), .res_valid(res_valid), .res_class(res_class),
    .res_sim(res_sim), .res_margin(res_margin), .res_correct(res_correct), .tally(tally)
  );

  am_seq_search #(.HV_DIM(HV_DIM), .NUM_CLASSES(NUM_CLASSES), .SEG_W(SEG_W), .TALLY_W(SMALL_TALLY_W)) dut_small (
    .clk(clk), .rst(rst), .en(en), .q_valid(q_valid2), .q_ready(q_ready2),
    .query_hv(query_hv), .correct_class(correct_class), .class_hvs(class_hvs),
    .tally_clr(tally_clr2), .res_valid(res_valid2), .res_class(res_class2),
    .res_sim(res_sim2), .res_margin(res_margin2), .res_correct(res_correct2), .tally(tally2)
  );

  typedef struct {
    int cls;
    int sim;
    int margin;
    int correct;
  } exp_t;

  exp_t pending[$];
  exp_t held;
  int   exp_tally;
  bit   armed;
  int   checks;
  int   errors;

  logic [HV_DIM-1:0] pat, rq1, rq2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scores are plain popcounts of the full-width AND; winner is the first
  // maximum, runner-up is the largest score among all other classes.
  function automatic exp_t modelOf(input logic [HV_DIM-1:0] q, input logic [CLS_W-1:0] lbl);
    int   s [NUM_CLASSES];
    int   bi;
    int   ru;
    exp_t e;
    for (int c = 0; c < NUM_CLASSES; c++) s[c] = $countones(q & class_hvs[c*HV_DIM +: HV_DIM]);
    bi = 0;
    for (int c = 1; c < NUM_CLASSES; c++) if (s[c] > s[bi]) bi = c;
    ru = -1;
    for (int c = 0; c < NUM_CLASSES; c++) if (c != bi && s[c] > ru) ru = s[c];
    e.cls = bi;
    e.sim = s[bi];
`ifdef AM_MARGIN_EN
    e.margin = s[bi] - ru;
`else
    e.margin = 0;
`endif
    e.correct = (int'(lbl) == bi) ? 1 : 0;
    return e;
  endfunction

  // Checks held results and tally every cycle, then predicts the next edge.
  task automatic compareCycle();
    if (!armed) return;
    if (res_valid === 1'b1) begin
      if (pending.size() == 0) checkOutput("unexpected_res_valid", res_valid, 0);
      else held = pending.pop_front();
    end
    if (en === 1'b0) checkOutput("res_valid_stalled", res_valid, 0);
    checkOutput("res_class", res_class, held.cls);
    checkOutput("res_sim", res_sim, held.sim);
    checkOutput("res_margin", res_margin, held.margin);
    checkOutput("res_correct", res_correct, held.correct);
    checkOutput("tally", tally, exp_tally);
    if (rst) begin
      held      = '{cls: 0, sim: 0, margin: 0, correct: 0};
      exp_tally = 0;
      pending.delete();
    end else if (en) begin
      if (tally_clr) exp_tally = 0;
      else if (res_valid === 1'b1 && held.correct == 1 && exp_tally < (1 << TALLY_W) - 1) exp_tally++;
    end
  endtask

  task automatic offerQuery(input logic [HV_DIM-1:0] q, input logic [CLS_W-1:0] lbl);
    int w = 0;
    while (q_ready !== 1'b1 && w < 100) begin tick(); w++; end
    if (q_ready !== 1'b1) checkOutput("q_ready_wait", q_ready, 1);
    pending.push_back(modelOf(q, lbl));
    query_hv      = q;
    correct_class = lbl;
    q_valid       = 1'b1;
    tick();
    q_valid       = 1'b0;
    query_hv      = ~q;
    correct_class = lbl + 1'b1;
    checkOutput("busy_q_ready", q_ready, 0);
  endtask

  // Runs one query to its DONE cycle with optional enable stalls, checking latency.
  task automatic applyStimulus(input logic [HV_DIM-1:0] q, input logic [CLS_W-1:0] lbl,
                               input int stall_a, input int len_a,
                               input int stall_b, input int len_b, input int exp_lat);
    int lat;
    offerQuery(q, lbl);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 200) begin
      en = !((lat >= stall_a && lat < stall_a + len_a) || (lat >= stall_b && lat < stall_b + len_b));
      tick();
      lat++;
    end
    en = 1'b1;
    checkOutput("latency", lat, exp_lat);
    checkOutput("done_q_ready", q_ready, 0);
  endtask

  task automatic afterDone();
    tick();
    checkOutput("res_valid_one_cycle", res_valid, 0);
    checkOutput("ready_after_done", q_ready, 1);
  endtask

  task automatic randomClasses();
    for (int c = 0; c < NUM_CLASSES; c++) begin
      int dens;
      dens = $urandom_range(10, 60);
      for (int i = 0; i < HV_DIM; i++)
        class_hvs[c*HV_DIM + i] = ($urandom_range(0, 99) < dens);
    end
  endtask

  task automatic randomHv(output logic [HV_DIM-1:0] v);
    for (int i = 0; i < HV_DIM; i++) v[i] = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    int seq [6] = '{1, 2, 3, 3, 3, 0};
    exp_t e;
    held          = '{cls: 0, sim: 0, margin: 0, correct: 0};
    exp_tally     = 0;
    armed         = 1'b0;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    en            = 1'b1;
    q_valid       = 1'b0;
    q_valid2      = 1'b0;
    tally_clr     = 1'b0;
    tally_clr2    = 1'b0;
    query_hv      = '0;
    correct_class = '0;
    class_hvs     = '0;
    for (int i = 0; i < HV_DIM; i++) pat[i] = (i % 4 == 0);

    fork
      begin
        tick();
        armed = 1'b1;
        tick();
        rst = 1'b0;
        $display("[TB] reset and idle");
        repeat (5) begin
          tick();
          checkOutput("idle_q_ready", q_ready, 1);
          checkOutput("idle_res_valid", res_valid, 0);
          checkOutput("idle_tally", tally, 0);
        end
        checkOutput("small_reset_tally", tally2, 0);

        $display("[TB] reset pulse mid-query");
        class_hvs[7*HV_DIM +: HV_DIM] = pat;
        offerQuery(pat, 5'd7);
        for (int i = 2; i <= 20; i++) begin
          tick();
          checkOutput("abort_no_result", res_valid, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_q_ready", q_ready, 1);
        repeat (40) begin
          tick();
          checkOutput("abort_no_result", res_valid, 0);
        end
        checkOutput("abort_tally", tally, 0);

        $display("[TB] single matching class");
        applyStimulus(pat, 5'd7, -100, 0, -100, 0, 37);
        checkOutput("a_class", res_class, 7);
        checkOutput("a_sim", res_sim, 1250);
        checkOutput("a_correct", res_correct, 1);
        checkOutput("a_tally_in_done", tally, 0);
        afterDone();
        checkOutput("a_tally", tally, 1);

        $display("[TB] tie between classes 3 and 12");
        class_hvs = '0;
        class_hvs[3*HV_DIM +: HV_DIM]  = pat;
        class_hvs[12*HV_DIM +: HV_DIM] = pat;
        applyStimulus(pat, 5'd12, -100, 0, -100, 0, 37);
        checkOutput("b_class", res_class, 3);
        checkOutput("b_sim", res_sim, 1250);
        checkOutput("b_margin", res_margin, 0);
        checkOutput("b_correct", res_correct, 0);
        afterDone();
        checkOutput("b_tally", tally, 1);

        $display("[TB] random classes, unstalled then stalled");
        randomClasses();
        randomHv(rq1);
        e = modelOf(rq1, '0);
        applyStimulus(rq1, CLS_W'(e.cls), -100, 0, -100, 0, 37);
        checkOutput("c_correct", res_correct, 1);
        afterDone();
        checkOutput("c_tally", tally, 2);
        applyStimulus(rq1, CLS_W'(e.cls), 3, 4, 20, 3, 44);
        checkOutput("c_stall_correct", res_correct, 1);
        afterDone();
        checkOutput("c_stall_tally", tally, 3);

        $display("[TB] out-of-range label");
        randomHv(rq2);
        applyStimulus(rq2, 5'd31, -100, 0, -100, 0, 37);
        checkOutput("e_correct", res_correct, 0);
        afterDone();
        checkOutput("e_tally", tally, 3);

        $display("[TB] tally clear with and without enable");
        en        = 1'b0;
        tally_clr = 1'b1;
        tick();
        checkOutput("clr_disabled", tally, 3);
        en = 1'b1;
        tick();
        tally_clr = 1'b0;
        checkOutput("clr_enabled", tally, 0);

        $display("[TB] 2-bit tally saturation");
        class_hvs = '0;
        class_hvs[7*HV_DIM +: HV_DIM] = pat;
        for (int n = 0; n < 6; n++) begin
          int w;
          w = 0;
          while (q_ready2 !== 1'b1 && w < 100) begin tick(); w++; end
          query_hv      = pat;
          correct_class = 5'd7;
          q_valid2      = 1'b1;
          tick();
          q_valid2 = 1'b0;
          w = 0;
          while (res_valid2 !== 1'b1 && w < 100) begin tick(); w++; end
          checkOutput("small_res_valid", res_valid2, 1);
          if (n == 5) begin
            checkOutput("small_tally_before_clr", tally2, 3);
            tally_clr2 = 1'b1;
          end
          tick();
          tally_clr2 = 1'b0;
          checkOutput("small_tally", tally2, seq[n]);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join
  end

endmodule
